// File: rtl/alu_op_sequencer_if.sv
// Command/response channel between a requester and the ALU operation sequencer.
// The master modport is the command source and response sink; the slave modport is the sequencer.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_use_acc;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_zero
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives one command at a time into an external combinational ALU; response valid one edge after accept.
// Holds the response until consumed; cmd_ready is low in EXEC and RESP, so commands stall there.
module alu_op_sequencer #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] ACC_INIT = '0,
  parameter int               CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_op_sequencer_if.slave   bus,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [1:0]          alu_sel,
  input  logic [WIDTH-1:0]    alu_result,
  output logic [WIDTH-1:0]    acc,
  output logic [CNT_W-1:0]    op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef struct packed {
    logic [1:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } alu_drv_t;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  alu_drv_t         drv_q;
  logic             rsp_vld_q;
  logic [WIDTH-1:0] rsp_dat_q;
  logic             rsp_zero_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic             cmd_fire;
  logic             rsp_fire;

  assign bus.cmd_ready = (state_q == IDLE);
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
  assign rsp_fire      = rsp_vld_q && bus.rsp_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ALU drive is captured only on the accept edge and otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_q <= '0;
    end else if (cmd_fire) begin
      drv_q.sel <= bus.cmd_op;
      drv_q.a   <= bus.cmd_use_acc ? acc_q : bus.cmd_a;
      drv_q.b   <= bus.cmd_b;
    end
  end

  // The ALU has had a full cycle to settle when EXEC closes; sample it there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q  <= 1'b0;
      rsp_dat_q  <= '0;
      rsp_zero_q <= 1'b0;
      acc_q      <= ACC_INIT;
    end else if (state_q == EXEC) begin
      rsp_vld_q  <= 1'b1;
      rsp_dat_q  <= alu_result;
      rsp_zero_q <= (alu_result == '0);
      acc_q      <= alu_result;
    end else if (rsp_fire) begin
      rsp_vld_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (rsp_fire) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign alu_a         = drv_q.a;
  assign alu_b         = drv_q.b;
  assign alu_sel       = drv_q.sel;
  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_data  = rsp_dat_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign acc           = acc_q;
  assign op_count      = cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_op_sequencer;
  logic       clk;
  logic       rst_n;
  logic [3:0] alu_a, alu_b, alu_result, acc;
  logic [1:0] alu_sel;
  logic [7:0] op_count;

  int tests;
  int fails;
  int exp_cnt;

  alu_op_sequencer_if #(.WIDTH(4)) bus ();

  alu_op_sequencer #(.WIDTH(4), .ACC_INIT(4'h0), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .acc        (acc),
    .op_count   (op_count)
  );

  always_comb begin
    case (alu_sel)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = alu_a & alu_b;
      2'b10:   alu_result = alu_a | alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic ua, output logic [3:0] d, output logic z, output logic tmo);
    int n;
    tmo = 1'b0;
    bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_use_acc = ua;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = 1'b0;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) tmo = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) tmo = 1'b1;
    d = bus.rsp_data;
    z = bus.rsp_zero;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    if (!tmo) exp_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b11; bus.cmd_a = 4'h7; bus.cmd_b = 4'h3;
    bus.cmd_use_acc = 1'b0; bus.rsp_ready = 1'b1;
    repeat (3) tick();
    tests++;
    if (alu_a !== 4'h0 || alu_sel !== 2'b00) begin
      fails++; $display("FAIL reset_no_accept: alu_a=%h sel=%b want 0/00", alu_a, alu_sel);
    end
    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    tests++;
    if (bus.rsp_valid !== 1'b0 || acc !== 4'h0 || op_count !== 8'd0 || bus.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL reset_state: rsp_valid=%b acc=%h cnt=%0d rdy=%b want 0/0/0/1",
                        bus.rsp_valid, acc, op_count, bus.cmd_ready);
    end
    tests++;
    if (alu_a !== 4'h0 || alu_b !== 4'h0 || alu_sel !== 2'b00) begin
      fails++; $display("FAIL reset_alu: a=%h b=%h sel=%b want 0/0/00", alu_a, alu_b, alu_sel);
    end
    bus.cmd_a = 4'h9;
    repeat (2) tick();
    tests++;
    if (alu_a !== 4'h0 || bus.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL idle_no_valid: alu_a=%h rdy=%b want 0/1", alu_a, bus.cmd_ready);
    end
    exp_cnt = 0;
  endtask

  task automatic test_add_wrap();
    bus.cmd_op = 2'b00; bus.cmd_a = 4'h9; bus.cmd_b = 4'h8; bus.cmd_use_acc = 1'b0;
    bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    tests++;
    if (alu_a !== 4'h9 || alu_b !== 4'h8 || alu_sel !== 2'b00 || bus.rsp_valid !== 1'b0
        || bus.cmd_ready !== 1'b0) begin
      fails++; $display("FAIL add_drive: a=%h b=%h sel=%b vld=%b rdy=%b want 9/8/00/0/0",
                        alu_a, alu_b, alu_sel, bus.rsp_valid, bus.cmd_ready);
    end
    tick();
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 4'h1 || bus.rsp_zero !== 1'b0 || acc !== 4'h1) begin
      fails++; $display("FAIL add_rsp: vld=%b data=%h zero=%b acc=%h want 1/1/0/1",
                        bus.rsp_valid, bus.rsp_data, bus.rsp_zero, acc);
    end
    tick();
    bus.rsp_ready = 1'b0;
    exp_cnt++;
    tests++;
    if (bus.rsp_valid !== 1'b0 || op_count !== 8'd1 || bus.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL add_done: vld=%b cnt=%0d rdy=%b want 0/1/1",
                        bus.rsp_valid, op_count, bus.cmd_ready);
    end
  endtask

  task automatic test_logic_ops();
    logic [3:0] d; logic z, t;
    issue(2'b11, 4'h5, 4'h5, 1'b0, d, z, t);
    tests++;
    if (t || d !== 4'h0 || z !== 1'b1) begin
      fails++; $display("FAIL xor_zero: data=%h zero=%b tmo=%b want 0/1/0", d, z, t);
    end
    issue(2'b10, 4'hA, 4'h5, 1'b0, d, z, t);
    tests++;
    if (t || d !== 4'hF || z !== 1'b0) begin
      fails++; $display("FAIL or_full: data=%h zero=%b tmo=%b want F/0/0", d, z, t);
    end
  endtask

  task automatic test_acc_chain();
    logic [3:0] d; logic z, t;
    logic [3:0] exp_sum [3] = '{4'h3, 4'h6, 4'h9};
    issue(2'b01, 4'hF, 4'h0, 1'b0, d, z, t);
    tests++;
    if (t || acc !== 4'h0) begin
      fails++; $display("FAIL acc_clear: acc=%h tmo=%b want 0/0", acc, t);
    end
    for (int i = 0; i < 3; i++) begin
      issue(2'b00, 4'hF, 4'h3, 1'b1, d, z, t);
      tests++;
      if (t || d !== exp_sum[i]) begin
        fails++; $display("FAIL acc_add%0d: data=%h tmo=%b want %h", i, d, t, exp_sum[i]);
      end
    end
    issue(2'b01, 4'hF, 4'hC, 1'b1, d, z, t);
    tests++;
    if (t || d !== 4'h8 || acc !== 4'h8) begin
      fails++; $display("FAIL acc_and: data=%h acc=%h tmo=%b want 8/8", d, acc, t);
    end
  endtask

  task automatic test_backpressure();
    int n;
    bus.cmd_op = 2'b00; bus.cmd_a = 4'h1; bus.cmd_b = 4'h2; bus.cmd_use_acc = 1'b0;
    bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b0;
    tick();
    bus.cmd_op = 2'b11; bus.cmd_a = 4'h6; bus.cmd_b = 4'h3;
    tick();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 4'h3 || bus.cmd_ready !== 1'b0
          || alu_a !== 4'h1 || op_count !== 8'(exp_cnt)) begin
        fails++; $display("FAIL bp_hold%0d: vld=%b data=%h rdy=%b a=%h cnt=%0d want 1/3/0/1/%0d",
                          i, bus.rsp_valid, bus.rsp_data, bus.cmd_ready, alu_a, op_count, exp_cnt);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    exp_cnt++;
    tests++;
    if (bus.rsp_valid !== 1'b0 || op_count !== 8'(exp_cnt) || bus.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL bp_release: vld=%b cnt=%0d rdy=%b want 0/%0d/1",
                        bus.rsp_valid, op_count, bus.cmd_ready, exp_cnt);
    end
    tick();
    bus.cmd_valid = 1'b0;
    tests++;
    if (alu_a !== 4'h6 || alu_b !== 4'h3 || alu_sel !== 2'b11) begin
      fails++; $display("FAIL bp_next_cmd: a=%h b=%h sel=%b want 6/3/11", alu_a, alu_b, alu_sel);
    end
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 10) begin tick(); n++; end
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 4'h5) begin
      fails++; $display("FAIL bp_next_rsp: vld=%b data=%h want 1/5", bus.rsp_valid, bus.rsp_data);
    end
    tick();
    bus.rsp_ready = 1'b0;
    exp_cnt++;
    tests++;
    if (op_count !== 8'(exp_cnt)) begin
      fails++; $display("FAIL bp_count: cnt=%0d want %0d", op_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_exec();
    bus.cmd_op = 2'b10; bus.cmd_a = 4'h3; bus.cmd_b = 4'h4; bus.cmd_use_acc = 1'b0;
    bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.rsp_valid !== 1'b0 || acc !== 4'h0 || op_count !== 8'd0 || alu_a !== 4'h0) begin
      fails++; $display("FAIL rst_exec: vld=%b acc=%h cnt=%0d a=%h want 0/0/0/0",
                        bus.rsp_valid, acc, op_count, alu_a);
    end
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
    repeat (2) tick();
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || acc !== 4'h0 || op_count !== 8'd0) begin
      fails++; $display("FAIL rst_exec_after: vld=%b rdy=%b acc=%h cnt=%0d want 0/1/0/0",
                        bus.rsp_valid, bus.cmd_ready, acc, op_count);
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_count_wrap();
    logic [3:0] d; logic z, t;
    int tmo_seen;
    tmo_seen = 0;
    for (int i = 0; i < 255; i++) begin
      issue(2'b00, 4'h1, 4'h1, 1'b0, d, z, t);
      if (t) tmo_seen++;
    end
    tests++;
    if (tmo_seen != 0 || op_count !== 8'd255) begin
      fails++; $display("FAIL cnt_255: cnt=%0d timeouts=%0d want 255/0", op_count, tmo_seen);
    end
    issue(2'b00, 4'h1, 4'h1, 1'b0, d, z, t);
    tests++;
    if (t || op_count !== 8'd0 || d !== 4'h2) begin
      fails++; $display("FAIL cnt_wrap: cnt=%0d data=%h tmo=%b want 0/2/0", op_count, d, t);
    end
  endtask

  initial begin
    tests = 0; fails = 0; exp_cnt = 0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_a = 4'h0; bus.cmd_b = 4'h0;
    bus.cmd_use_acc = 1'b0; bus.rsp_ready = 1'b0;
    test_reset();
    test_add_wrap();
    test_logic_ops();
    test_acc_chain();
    test_backpressure();
    test_reset_mid_exec();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the 4-bit ALU operand/select interface.
- Accepts operation commands over a valid/ready handshake and drives operands and select to an external combinational ALU.
- Captures the ALU result and returns it over a valid/ready response channel with a zero flag.
- Keeps a result accumulator so chained operations can run without re-supplying operand a.

Parameters:
WIDTH, 4, operand/result bit width; must match the attached ALU
ACC_INIT, 0, accumulator value after reset (WIDTH bits)
CNT_W, 8, width of completed-operation counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept command
cmd_op  in  2  00 add, 01 and, 10 or, 11 xor
cmd_a  in  WIDTH  operand a (ignored when cmd_use_acc=1)
cmd_b  in  WIDTH  operand b
cmd_use_acc  in  1  1: operand a taken from acc
alu_a  out  WIDTH  registered operand a to ALU
alu_b  out  WIDTH  registered operand b to ALU
alu_sel  out  2  registered select to ALU
alu_result  in  WIDTH  combinational ALU result
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_data  out  WIDTH  captured result
rsp_zero  out  1  rsp_data == 0
acc  out  WIDTH  accumulator (last captured result)
op_count  out  CNT_W  completed responses, wraps

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; alu_a, alu_b, alu_sel, rsp_data = 0; rsp_valid = 0; rsp_zero = 0; acc = ACC_INIT; op_count = 0.
  - No handshake is accepted while rst_n is low.
- FSM states IDLE, EXEC, RESP. All outputs are registered except cmd_ready, which is decoded as (state==IDLE).
- IDLE: on a cmd_valid && cmd_ready edge:
  - alu_a <= cmd_use_acc ? acc : cmd_a; alu_b <= cmd_b; alu_sel <= cmd_op.
  - Go to EXEC.
- EXEC: exactly one cycle for the ALU to settle. At the closing edge:
  - rsp_data <= alu_result; acc <= alu_result; rsp_zero <= (alu_result==0); rsp_valid <= 1.
  - Go to RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_zero hold stable until rsp_ready=1.
  - On the rsp_valid && rsp_ready edge: rsp_valid <= 0; op_count <= op_count+1, wrapping from all-ones to 0; go to IDLE.
- Latency and throughput:
  - Command accepted at edge k, so alu_* update at edge k and rsp_valid rises at edge k+1.
  - Minimum 3 cycles per operation. cmd_ready is 0 in EXEC and RESP, so commands offered there are not consumed.
- alu_a/alu_b/alu_sel hold their last values outside the IDLE accept edge.
- Arithmetic: the sequencer never modifies alu_result. Add overflow wraps mod 2^WIDTH inside the ALU; no carry is reported.
- acc updates only at the EXEC capture edge. A use_acc command issued immediately after a response uses that response's value.
- rsp_zero is meaningful only while rsp_valid=1.
- Reset in EXEC or RESP discards the in-flight operation with no response. acc returns to ACC_INIT and op_count to 0.
- cmd_valid deasserted before acceptance has no effect. Command inputs are sampled only on the accept edge.

Test Plan:
- Reset, then release -> rsp_valid=0, acc=0, op_count=0, alu_a/b/sel=0, cmd_ready=1 in the first cycle after release.
- ADD a=9, b=8 -> alu_a=9, alu_b=8, alu_sel=00 one edge after accept; rsp_valid high the next edge with rsp_data=1 (wrap) and rsp_zero=0; op_count=1 after handshake.
- XOR a=5, b=5 -> rsp_data=0, rsp_zero=1. Then OR a=4'hA, b=4'h5 -> rsp_data=4'hF, rsp_zero=0.
- Accumulate chain, acc=0, use_acc=1:
  - ADD b=3 three times -> 3, 6, 9.
  - AND b=4'hC -> 8, acc=8.
  - cmd_a=4'hF is applied throughout and must be ignored.
- Backpressure: hold rsp_ready=0 for 5 cycles while cmd_valid=1 with new data -> rsp_valid/rsp_data stable, cmd_ready=0, the new command is not taken until after the response handshake; op_count increments exactly once.
- Reset asserted mid-EXEC -> rsp_valid stays 0, acc=0, op_count=0, IDLE after release. Separately, 256 completed ops -> op_count wraps 255->0.
